// File: rtl/vga_mode_sequencer.sv
// Sequences VGA resolution changes onto the config bus: each write is deferred to a
// frame boundary, confirmed by c_ready, retried once on timeout, and the confirmed mode tracked.
module vga_mode_sequencer #(
    parameter int unsigned               CONFIG_WIDTH    = 8,
    parameter logic [CONFIG_WIDTH-1:0]   ADDR_VGA_CONFIG = 8'h01,
    parameter int unsigned               TIMEOUT_CYCLES  = 16,
    parameter int unsigned               TIMER_WIDTH     = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    input  logic [1:0]              req_mode,
    output logic                    req_ready,
    input  logic                    frame_end,
    output logic                    c_valid,
    output logic [CONFIG_WIDTH-1:0] c_addr,
    output logic [CONFIG_WIDTH-1:0] c_data,
    input  logic                    c_ready,
    output logic                    busy,
    output logic [1:0]              cur_mode,
    output logic                    done,
    output logic                    mode_err,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_ISSUE      = 2'd2,
        S_WAIT_ACK   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    // The timer holds completed WAIT_ACK cycles, so this value means the current
    // cycle is the one that brings it to TIMEOUT_CYCLES.
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    logic [1:0]              r_mode_latched;
    logic                    r_retry;
    logic [TIMER_WIDTH-1:0]  r_timer;
    logic [1:0]              r_cur_mode;
    logic                    r_c_valid;
    logic [CONFIG_WIDTH-1:0] r_c_addr;
    logic [CONFIG_WIDTH-1:0] r_c_data;
    logic                    r_busy;
    logic                    r_req_ready;
    logic                    r_done;
    logic                    r_mode_err;
    logic                    r_timeout_err;

    state_t                  w_state_next;
    logic [1:0]              w_mode_latched_next;
    logic                    w_retry_next;
    logic [TIMER_WIDTH-1:0]  w_timer_next;
    logic [1:0]              w_cur_mode_next;
    logic                    w_c_valid_next;
    logic [CONFIG_WIDTH-1:0] w_c_addr_next;
    logic [CONFIG_WIDTH-1:0] w_c_data_next;
    logic                    w_busy_next;
    logic                    w_done_next;
    logic                    w_mode_err_next;
    logic                    w_timeout_err_next;

    logic                    w_req_illegal;
    logic                    w_req_same;
    logic                    w_ack;
    logic                    w_timer_hit;

    assign w_req_illegal = req_valid && (req_mode == MODE_ILLEGAL);
    assign w_req_same    = req_valid && (req_mode != MODE_ILLEGAL) && (req_mode == r_cur_mode);
    assign w_ack         = (r_state == S_WAIT_ACK) && c_ready;
    assign w_timer_hit   = (r_state == S_WAIT_ACK) && !c_ready && (r_timer == TIMER_LAST);

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_mode_latched <= 2'b00;
            r_retry        <= 1'b0;
            r_timer        <= '0;
            r_cur_mode     <= 2'b00;
            r_c_valid      <= 1'b0;
            r_c_addr       <= '0;
            r_c_data       <= '0;
            r_busy         <= 1'b0;
            r_req_ready    <= 1'b1;
            r_done         <= 1'b0;
            r_mode_err     <= 1'b0;
            r_timeout_err  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge
            // values of its peers, independent of statement order.
            r_state        <= w_state_next;
            r_mode_latched <= w_mode_latched_next;
            r_retry        <= w_retry_next;
            r_timer        <= w_timer_next;
            r_cur_mode     <= w_cur_mode_next;
            r_c_valid      <= w_c_valid_next;
            r_c_addr       <= w_c_addr_next;
            r_c_data       <= w_c_data_next;
            r_busy         <= w_busy_next;
            r_req_ready    <= !w_busy_next;
            r_done         <= w_done_next;
            r_mode_err     <= w_mode_err_next;
            r_timeout_err  <= w_timeout_err_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every target gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_state_next        = r_state;
        w_mode_latched_next = r_mode_latched;
        w_retry_next        = r_retry;
        w_timer_next        = '0;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid && !w_req_illegal && !w_req_same) begin
                    w_state_next        = S_WAIT_FRAME;
                    w_mode_latched_next = req_mode;
                    w_retry_next        = 1'b0;
                end
            end
            S_WAIT_FRAME: begin
                if (frame_end) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (c_ready) begin
                    w_state_next = S_IDLE;
                end else if (w_timer_hit) begin
                    // First timeout retries at the next frame; second gives up.
                    if (!r_retry) begin
                        w_retry_next = 1'b1;
                        w_state_next = S_WAIT_FRAME;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        w_c_valid_next     = (w_state_next == S_ISSUE);
        w_c_addr_next      = w_c_valid_next ? ADDR_VGA_CONFIG : '0;
        w_c_data_next      = w_c_valid_next ? CONFIG_WIDTH'(r_mode_latched) : '0;
        w_busy_next        = (w_state_next != S_IDLE);
        w_cur_mode_next    = w_ack ? r_mode_latched : r_cur_mode;
        w_done_next        = ((r_state == S_IDLE) && w_req_same) || w_ack;
        w_mode_err_next    = (r_state == S_IDLE) && w_req_illegal;
        w_timeout_err_next = w_timer_hit && r_retry;
    end

    assign req_ready   = r_req_ready;
    assign c_valid     = r_c_valid;
    assign c_addr      = r_c_addr;
    assign c_data      = r_c_data;
    assign busy        = r_busy;
    assign cur_mode    = r_cur_mode;
    assign done        = r_done;
    assign mode_err    = r_mode_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: a request table, a bus-write scoreboard
// fed by a VGA ack model, and hand sequences for frame-edge, timeout/retry and reset cases.
module tb_vga_mode_sequencer;

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] ADDR = 8'h01;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [1:0]    req_mode;
    logic          req_ready;
    logic          frame_end;
    logic          c_valid;
    logic [CW-1:0] c_addr;
    logic [CW-1:0] c_data;
    logic          c_ready;
    logic          busy;
    logic [1:0]    cur_mode;
    logic          done;
    logic          mode_err;
    logic          timeout_err;

    logic          ack_en;
    logic          prev_c_valid;
    int            n_checks = 0;
    int            n_errors = 0;

    typedef struct packed {
        logic [CW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [1:0] mode;
        int         delay;
        logic       exp_err;
        logic       exp_skip;
        logic [1:0] exp_cur;
    } vec_t;
    vec_t vecs[8];

    vga_mode_sequencer #(
        .CONFIG_WIDTH   (CW),
        .ADDR_VGA_CONFIG(ADDR),
        .TIMEOUT_CYCLES (16),
        .TIMER_WIDTH    (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_mode   (req_mode),
        .req_ready  (req_ready),
        .frame_end  (frame_end),
        .c_valid    (c_valid),
        .c_addr     (c_addr),
        .c_data     (c_data),
        .c_ready    (c_ready),
        .busy       (busy),
        .cur_mode   (cur_mode),
        .done       (done),
        .mode_err   (mode_err),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // VGA model: Load_config follows a sampled c_valid by one cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_ready <= 1'b0;
        else        c_ready <= c_valid && ack_en;
    end

    // Bus monitor: every write must match the scoreboard; idle bus must be zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (c_valid) begin
                check("no_back_to_back_c_valid", 32'(prev_c_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(c_addr), 32'(e.addr));
                    check("write_data", 32'(c_data), 32'(e.data));
                end
            end else begin
                check("idle_bus_zero", {16'd0, c_addr, c_data}, 32'd0);
            end
            prev_c_valid = c_valid;
        end else begin
            prev_c_valid = 1'b0;
        end
    end

    // Drive frame_end at the current negedge and follow the write to completion.
    task automatic finish_write(input logic [1:0] mode);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        check("c_valid_after_frame", 32'(c_valid), 32'd1);
        @(negedge clk);
        check("c_valid_single", 32'(c_valid), 32'd0);
        check("done_not_early", 32'(done), 32'd0);
        check("busy_in_ack", 32'(busy), 32'd1);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd1);
        check("req_ready_back", 32'(req_ready), 32'd1);
        check("busy_cleared", 32'(busy), 32'd0);
        check("cur_mode_updated", 32'(cur_mode), 32'(mode));
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] cur_before;
        cur_before = cur_mode;
        req_valid = 1'b1;
        req_mode  = v.mode;
        @(negedge clk);
        req_valid = 1'b0;
        check("mode_err_pulse", 32'(mode_err), 32'(v.exp_err));
        check("skip_done", 32'(done), 32'(v.exp_skip));
        check("busy_after_req", 32'(busy), 32'(!(v.exp_err || v.exp_skip)));
        if (v.exp_err || v.exp_skip) begin
            check("cur_mode_kept", 32'(cur_mode), 32'(cur_before));
            @(negedge clk);
            check("pulses_clear", {30'd0, mode_err, done}, 32'd0);
        end else begin
            exp_q.push_back('{addr: ADDR, data: CW'(v.mode)});
            repeat (v.delay) @(negedge clk);
            finish_write(v.mode);
        end
        check("table_cur_mode", 32'(cur_mode), 32'(v.exp_cur));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode: 2'b01, delay: 5, exp_err: 1'b0, exp_skip: 1'b0, exp_cur: 2'b01};
        vecs[1] = '{mode: 2'b11, delay: 0, exp_err: 1'b1, exp_skip: 1'b0, exp_cur: 2'b01};
        vecs[2] = '{mode: 2'b01, delay: 0, exp_err: 1'b0, exp_skip: 1'b1, exp_cur: 2'b01};
        vecs[3] = '{mode: 2'b00, delay: 1, exp_err: 1'b0, exp_skip: 1'b0, exp_cur: 2'b00};
        vecs[4] = '{mode: 2'b10, delay: 3, exp_err: 1'b0, exp_skip: 1'b0, exp_cur: 2'b10};
        vecs[5] = '{mode: 2'b10, delay: 0, exp_err: 1'b0, exp_skip: 1'b1, exp_cur: 2'b10};
        vecs[6] = '{mode: 2'b11, delay: 0, exp_err: 1'b1, exp_skip: 1'b0, exp_cur: 2'b10};
        vecs[7] = '{mode: 2'b01, delay: 0, exp_err: 1'b0, exp_skip: 1'b0, exp_cur: 2'b01};

        rst_n = 1'b0; req_valid = 1'b0; req_mode = 2'b00; frame_end = 1'b0; ack_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cur_mode", 32'(cur_mode), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_outputs", {27'd0, busy, c_valid, done, mode_err, timeout_err}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_state", {26'd0, req_ready, busy, c_valid, done, mode_err, timeout_err},
                  32'h20);
        end
        check("idle_cur_mode", 32'(cur_mode), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // frame_end coincident with the accepting edge is ignored; req_valid ignored while busy.
        req_valid = 1'b1; req_mode = 2'b10; frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0; req_mode = 2'b11;
        check("accept_edge_busy", 32'(busy), 32'd1);
        exp_q.push_back('{addr: ADDR, data: 8'h02});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_write_before_frame", 32'(c_valid), 32'd0);
            check("busy_ignores_req", 32'(mode_err), 32'd0);
        end
        req_valid = 1'b0;
        finish_write(2'b10);

        // Timeout with retry, then timeout_err.
        ack_en = 1'b0;
        req_valid = 1'b1; req_mode = 2'b00;
        @(negedge clk);
        req_valid = 1'b0;
        exp_q.push_back('{addr: ADDR, data: 8'h00});
        exp_q.push_back('{addr: ADDR, data: 8'h00});
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        check("first_try_c_valid", 32'(c_valid), 32'd1);
        repeat (16) @(negedge clk);
        frame_end = 1'b1;                 // sampled on the timeout edge: must be ignored
        @(negedge clk);
        check("frame_in_ack_ignored", 32'(c_valid), 32'd0);
        check("busy_during_retry", 32'(busy), 32'd1);
        @(negedge clk);                   // sampled back in WAIT_FRAME: accepted
        frame_end = 1'b0;
        check("retry_c_valid", 32'(c_valid), 32'd1);
        repeat (16) @(negedge clk);
        check("no_early_timeout", 32'(timeout_err), 32'd0);
        check("busy_before_timeout", 32'(busy), 32'd1);
        @(negedge clk);
        check("timeout_err_pulse", 32'(timeout_err), 32'd1);
        check("timeout_req_ready", 32'(req_ready), 32'd1);
        check("timeout_cur_mode", 32'(cur_mode), 32'd2);
        check("timeout_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("timeout_err_one_cycle", 32'(timeout_err), 32'd0);

        // Asynchronous reset while waiting for ack.
        req_valid = 1'b1; req_mode = 2'b01;
        @(negedge clk);
        req_valid = 1'b0;
        exp_q.push_back('{addr: ADDR, data: 8'h01});
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_req_ready", 32'(req_ready), 32'd1);
        check("async_rst_cur_mode", 32'(cur_mode), 32'd0);
        check("async_rst_pulses", {29'd0, c_valid, done, timeout_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        run_vec('{mode: 2'b10, delay: 2, exp_err: 1'b0, exp_skip: 1'b0, exp_cur: 2'b10});

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_mode_sequencer.md
Name: vga_mode_sequencer

Overview:
- Controller that changes the VGA resolution safely by sequencing writes on the VGA configuration bus (c_valid/c_addr/c_data, acknowledged by c_ready, which is the VGA Load_config output).
- Accepts mode-change requests from the host side and defers each bus write to a frame boundary.
- Confirms the write via c_ready, retries once on timeout, and tracks the currently programmed mode.
- Sits between the system control logic and the VGA block's config port.

Parameters:
- CONFIG_WIDTH, 8, width of c_addr/c_data; must match the VGA config bus.
- ADDR_VGA_CONFIG, 8'h01, address the VGA decodes as its resolution register.
- TIMEOUT_CYCLES, 16, WAIT_ACK cycles without c_ready before timeout; legal range 2..2^TIMER_WIDTH-1.
- TIMER_WIDTH, 5, width of the ack timer.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  host requests a mode change.
- req_mode  in  2  requested mode: 00=640x480, 01=800x600, 10=1024x768, 11=illegal.
- req_ready  out  1  sequencer can accept a request.
- frame_end  in  1  one-cycle pulse from the VGA vertical counter wrap.
- c_valid  out  1  config bus write strobe.
- c_addr  out  CONFIG_WIDTH  config bus address.
- c_data  out  CONFIG_WIDTH  config bus data.
- c_ready  in  1  VGA Load_config acknowledge.
- busy  out  1  transaction in progress.
- cur_mode  out  2  last mode confirmed by c_ready.
- done  out  1  one-cycle pulse: request completed successfully or was skipped.
- mode_err  out  1  one-cycle pulse: illegal mode rejected.
- timeout_err  out  1  one-cycle pulse: write failed after retry.

Behaviour:
- Outputs: all outputs are registered.
- Reset values: state IDLE; c_valid=0, c_addr=0, c_data=0, req_ready=1, busy=0, cur_mode=2'b00 (matches VGA reset mode), done=0, mode_err=0, timeout_err=0, retry flag=0, timer=0.
- Reset mid-operation: returns to these values immediately; any pending request is discarded.
- States: IDLE, WAIT_FRAME, ISSUE, WAIT_ACK.
- busy=1 in any state other than IDLE; req_ready is the inverse of busy.
- IDLE, req_valid sampled high:
  - req_mode=11: mode_err pulses next cycle, stay IDLE, no bus traffic.
  - req_mode==cur_mode: done pulses next cycle, stay IDLE, no bus traffic.
  - Otherwise: latch req_mode, clear retry flag, go to WAIT_FRAME.
- WAIT_FRAME:
  - Wait for a frame_end sampled in this state. A frame_end coincident with the accepting edge is ignored.
  - On frame_end: go to ISSUE.
  - req_valid is ignored while busy.
- ISSUE (exactly one cycle):
  - c_valid=1, c_addr=ADDR_VGA_CONFIG, c_data=latched mode zero-extended to CONFIG_WIDTH.
  - Then go to WAIT_ACK with timer=0.
- c_addr/c_data are 0 whenever c_valid=0.
- WAIT_ACK:
  - c_ready sampled high: cur_mode<=latched mode, done pulses, go to IDLE.
  - Otherwise the timer increments each cycle.
  - Timer reaches TIMEOUT_CYCLES with retry flag clear: set retry flag, go to WAIT_FRAME (retry at the next frame).
  - Timer reaches TIMEOUT_CYCLES with retry flag set: timeout_err pulses, cur_mode unchanged, go to IDLE.
  - c_ready on the same cycle the timer reaches TIMEOUT_CYCLES: c_ready wins (success).
- c_ready in any state other than WAIT_ACK is ignored.
- The VGA asserts Load_config one cycle after c_valid is sampled. With frame_end sampled at edge E:
  - c_valid is high after E.
  - c_ready is sampled at E+2.
  - done is high after E+2; req_ready returns high at the same time.
- At most one c_valid pulse per frame_end; never two consecutive c_valid cycles.

Test Plan:
- Reset, idle 10 cycles -> cur_mode=00, req_ready=1, c_valid never asserted, all pulses 0.
- req_mode=01 accepted; frame_end 5 cycles later; model VGA acks one cycle after c_valid -> single c_valid with c_addr=8'h01, c_data=8'h01; done after 2 more cycles; cur_mode=01; busy low.
- req_mode=11 -> mode_err single pulse next cycle; busy stays 0; no c_valid. req_mode equal to cur_mode -> done pulse, no c_valid.
- req_mode=10 with frame_end asserted on the accepting cycle -> no c_valid until the following frame_end; then c_data=8'h02.
- c_ready held 0 -> c_valid pulse; 16 cycles later returns to WAIT_FRAME; second c_valid on the next frame_end; 16 more cycles -> timeout_err pulse, cur_mode unchanged, req_ready=1.
- rst_n low during WAIT_ACK -> all outputs at reset values asynchronously; cur_mode=00; a new request after release completes normally.
